// File: rtl/decode_opcodes_pkg.sv
// Shared opcode header: major opcode values carried in ins[15:12].
// Latency: n/a (constants only).
// Backpressure: n/a.
package decode_opcodes_pkg;

    localparam int OP_LSB = 12;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OP_W-1:0] OP_JMP    = 4'h1;
    localparam logic [OP_W-1:0] OP_BN     = 4'h2;
    localparam logic [OP_W-1:0] OP_B      = 4'h3;
    localparam logic [OP_W-1:0] OP_JMPIMM = 4'h4;

endpackage

// File: rtl/decode_pkg.sv
// Decoder types: micro-op record, pc_src encodings, decode FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package decode_pkg;

    // arg_a / src_b are sized for the widest legal register address (REG_AW=4);
    // narrower configurations leave the upper bits at zero.
    localparam int REG_AW_MAX = 4;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_REL = 2'b01,
        PC_IMM = 2'b10,
        PC_REG = 2'b11
    } pc_src_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_EXT = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic                  read_a;
        logic                  imm_a;
        logic [REG_AW_MAX:0]   arg_a;
        logic                  read_b;
        logic [REG_AW_MAX-1:0] src_b;
        logic [1:0]            pc_src;
        logic                  set_pc;
        logic                  add_pc;
        logic                  inc_pc;
        logic [2:0]            cmp_b;
        logic [1:0]            out_regs;
        logic [15:0]           imm16;
        logic                  illegal;
    } uop_t;

endpackage

// File: rtl/decode_queue.sv
// Micro-op FIFO of DEPTH entries between the decoder and its consumer.
// Latency: push visible at out_vld the cycle after; no same-cycle bypass.
// Backpressure: in_rdy = !full | out_rdy, so a full queue accepts when popped the same cycle.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic cpu_clk,
    input  logic cpu_rst_n,
    input  logic in_vld,
    output logic in_rdy,
    input  uop_t in_dat,
    output logic out_vld,
    input  logic out_rdy,
    output uop_t out_dat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    uop_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign in_rdy  = !full || out_rdy;
    assign out_vld = !empty;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    // Empty slots present zeros so a reset or drained queue shows a clean uop.
    assign out_dat = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care while unoccupied.
    always_ff @(posedge cpu_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy 0..DEPTH.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Instruction decoder: 16-bit words -> uop_t, two-word JMPIMM, queued output. Option: DECODE_ILLEGAL_TRAP_EN.
// Latency: one cycle from accepted word to uop_valid when the queue is empty.
// Backpressure: ins_ready follows queue space (or same-cycle pop); a JMPIMM first word is always taken.
module decode_pipe
    import decode_pkg::*;
    import decode_opcodes_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        ins_valid,
    input  logic [15:0] ins,
    output logic        ins_ready,
    output logic        uop_valid,
    input  logic        uop_ready,
    output uop_t        uop,
    output logic        busy
);

    dec_state_e        state_q;
    dec_state_e        state_d;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] reg_a;
    logic [REG_AW-1:0] reg_b;
    logic [4:0]        imm5;
    logic              fn1;
    logic [1:0]        fn2;
    logic              jmpimm_first;
    logic              q_in_rdy;
    logic              ins_accept;
    logic              emit;
    uop_t              dec;
    logic              unused_ins;

    assign op    = ins[OP_LSB +: OP_W];
    assign reg_a = ins[2 +: REG_AW];
    assign reg_b = ins[6 +: REG_AW];
    assign imm5  = ins[5:1];
    assign fn1   = ins[0];
    assign fn2   = ins[1:0];
    assign unused_ins = ^ins[11:10];

    // A JMPIMM opening word produces no uop, so it never needs queue space.
    assign jmpimm_first = (state_q == ST_IDLE) && (op == OP_JMPIMM);
    assign ins_ready    = cpu_rst_n && (q_in_rdy || jmpimm_first);
    assign ins_accept   = ins_valid && ins_ready;
    assign busy         = (state_q == ST_WAIT_EXT) || uop_valid;

    // Decode state register; reset drops any half-received JMPIMM.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and micro-op for the word currently on ins.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        dec     = '0;
        case (state_q)
            ST_IDLE: begin
                if (op == OP_JMPIMM) begin
                    if (ins_accept) begin
                        state_d = ST_WAIT_EXT;
                    end
                end else begin
                    emit = 1'b1;
                    case (op)
                        OP_NOP: begin
                        end
                        OP_JMP: begin
                            dec.read_a = 1'b1;
                            dec.arg_a  = (REG_AW_MAX + 1)'(reg_a);
                            dec.read_b = 1'b1;
                            dec.src_b  = REG_AW_MAX'(reg_b);
                            dec.set_pc = 1'b1;
                            dec.pc_src = PC_REG;
                        end
                        OP_BN: begin
                            dec.imm_a  = 1'b1;
                            dec.arg_a  = (REG_AW_MAX + 1)'(imm5[REG_AW:0]);
                            dec.read_b = 1'b1;
                            dec.src_b  = REG_AW_MAX'(reg_b);
                            dec.add_pc = 1'b1;
                            dec.inc_pc = 1'b1;
                            dec.cmp_b  = {1'b0, fn1, 1'b1};
                            dec.pc_src = PC_REL;
                        end
                        OP_B: begin
                            dec.read_a = 1'b1;
                            dec.arg_a  = (REG_AW_MAX + 1)'(reg_a);
                            dec.read_b = 1'b1;
                            dec.src_b  = REG_AW_MAX'(reg_b);
                            dec.add_pc = 1'b1;
                            dec.inc_pc = 1'b1;
                            dec.cmp_b  = {fn2, 1'b1};
                            dec.pc_src = PC_REL;
                        end
                        default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                            dec.illegal = 1'b1;
`else
                            dec.illegal = 1'b0;
`endif
                        end
                    endcase
                end
            end
            ST_WAIT_EXT: begin
                // Whatever arrives here is the extension word, regardless of its top bits.
                emit       = 1'b1;
                dec.set_pc = 1'b1;
                dec.pc_src = PC_IMM;
                dec.imm16  = ins;
                if (ins_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    decode_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .in_vld    (ins_accept && emit),
        .in_rdy    (q_in_rdy),
        .in_dat    (dec),
        .out_vld   (uop_valid),
        .out_rdy   (uop_ready),
        .out_dat   (uop)
    );

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed table, corner sequences, randomized traffic.
// Latency: n/a.
// Backpressure: uop_ready driven directly by the stimulus.
module tb_decode_pipe;
    import decode_pkg::*;
    import decode_opcodes_pkg::*;

    localparam int REG_AW = 4;
    localparam int DEPTH  = 2;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        ins_valid;
    logic [15:0] ins;
    logic        ins_ready;
    logic        uop_valid;
    logic        uop_ready;
    uop_t        uop;
    logic        busy;

    int n_chk;
    int n_fail;
    int n_dut_pops;

    uop_t mq[$];
    bit   m_wait;

    typedef struct {
        string       name;
        logic [15:0] w;
        uop_t        exp;
    } vec_t;

    vec_t tbl[7];

    decode_pipe #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .ins_valid (ins_valid),
        .ins       (ins),
        .ins_ready (ins_ready),
        .uop_valid (uop_valid),
        .uop_ready (uop_ready),
        .uop       (uop),
        .busy      (busy)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic uop_t mk(input logic ra, input logic ia, input int arg, input logic rb,
                                input int srcb, input logic [1:0] pcs, input logic sp,
                                input logic ap, input logic ip, input logic [2:0] cmp);
        uop_t u;
        u        = '0;
        u.read_a = ra;
        u.imm_a  = ia;
        u.arg_a  = 5'(arg);
        u.read_b = rb;
        u.src_b  = 4'(srcb);
        u.pc_src = pcs;
        u.set_pc = sp;
        u.add_pc = ap;
        u.inc_pc = ip;
        u.cmp_b  = cmp;
        return u;
    endfunction

    // Reference decode computed arithmetically from the instruction-set rules.
    function automatic uop_t ref_uop(input logic [15:0] w);
        uop_t u;
        int wi, opc, ra, rb, imm5;
        u    = '0;
        wi   = int'(w);
        opc  = wi >> 12;
        ra   = (wi >> 2) % (1 << REG_AW);
        rb   = (wi >> 6) % (1 << REG_AW);
        imm5 = (wi >> 1) % 32;
        if (opc == int'(OP_JMP)) begin
            u = mk(1, 0, ra, 1, rb, 2'b11, 1, 0, 0, 3'b000);
        end else if (opc == int'(OP_BN)) begin
            u = mk(0, 1, imm5 % (1 << (REG_AW + 1)), 1, rb, 2'b01, 0, 1, 1, 3'(2 * (wi % 2) + 1));
        end else if (opc == int'(OP_B)) begin
            u = mk(1, 0, ra, 1, rb, 2'b01, 0, 1, 1, 3'(2 * (wi % 4) + 1));
        end else if (opc != int'(OP_NOP)) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            u.illegal = 1'b1;
`endif
        end
        return u;
    endfunction

    function automatic uop_t ext_uop(input logic [15:0] w);
        uop_t u;
        u        = '0;
        u.set_pc = 1'b1;
        u.pc_src = 2'b10;
        u.imm16  = w;
        return u;
    endfunction

    // One clock of stimulus: drive, compare against the model, then advance the model.
    task automatic cycle(input logic v, input logic [15:0] w, input logic r);
        bit exp_rdy;
        bit is_jmpimm;
        @(negedge cpu_clk);
        ins_valid = v;
        ins       = w;
        uop_ready = r;
        #1;
        is_jmpimm = (int'(w) >> 12) == int'(OP_JMPIMM);
        exp_rdy   = (!m_wait && is_jmpimm) || (mq.size() < DEPTH) || r;
        check("ins_ready", ins_ready, exp_rdy);
        check("uop_valid", uop_valid, mq.size() != 0);
        check("busy", busy, m_wait || (mq.size() != 0));
        if (mq.size() != 0) begin
            check("uop", uop, mq[0]);
        end
        if (uop_valid && r) begin
            n_dut_pops++;
        end
        if (mq.size() != 0 && r) begin
            void'(mq.pop_front());
        end
        if (v && exp_rdy) begin
            if (m_wait) begin
                mq.push_back(ext_uop(w));
                m_wait = 1'b0;
            end else if (is_jmpimm) begin
                m_wait = 1'b1;
            end else begin
                mq.push_back(ref_uop(w));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b0;
        ins_valid = 1'b1;
        ins       = 16'h3000;
        uop_ready = 1'b1;
        #1;
        check("rst_ins_ready", ins_ready, 0);
        check("rst_uop_valid", uop_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_uop", uop, 0);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        ins_valid = 1'b0;
        mq.delete();
        m_wait = 1'b0;
        #1;
        check("rst_release_rdy", ins_ready, 1);
    endtask

    initial begin
        int   d0;
        uop_t u_ill;
        uop_t u_ext;
        n_chk      = 0;
        n_fail     = 0;
        n_dut_pops = 0;
        m_wait     = 1'b0;
        cpu_rst_n  = 1'b0;
        ins_valid  = 1'b0;
        ins        = '0;
        uop_ready  = 1'b0;

        u_ill = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        u_ill.illegal = 1'b1;
`endif
        tbl[0] = '{"b_fn2_10",   16'h314E, mk(1, 0, 3,  1, 5,  2'b01, 0, 1, 1, 3'b101)};
        tbl[1] = '{"jmp",        16'h109F, mk(1, 0, 7,  1, 2,  2'b11, 1, 0, 0, 3'b000)};
        tbl[2] = '{"bn_fn1_1",   16'h226D, mk(0, 1, 22, 1, 9,  2'b01, 0, 1, 1, 3'b011)};
        tbl[3] = '{"bn_fn1_0",   16'h203E, mk(0, 1, 31, 1, 0,  2'b01, 0, 1, 1, 3'b001)};
        tbl[4] = '{"nop",        16'h0ABC, '0};
        tbl[5] = '{"unknown_op", 16'hF123, u_ill};
        tbl[6] = '{"b_fn2_11",   16'h33FF, mk(1, 0, 15, 1, 15, 2'b01, 0, 1, 1, 3'b111)};

        do_reset();

        // Directed single-word decodes, each checked one cycle after acceptance.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, tbl[i].w, 1'b1);
            @(posedge cpu_clk);
            #1;
            check({tbl[i].name, "_vld"}, uop_valid, 1);
            check(tbl[i].name, uop, tbl[i].exp);
            cycle(1'b0, 16'h0000, 1'b1);
        end

        // JMPIMM, idle gap, extension word: exactly one immediate-jump uop.
        d0 = n_dut_pops;
        u_ext = ext_uop(16'hBEEF);
        cycle(1'b1, 16'h4777, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'hBEEF, 1'b1);
        @(posedge cpu_clk);
        #1;
        check("jmpimm_ext", uop, u_ext);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        check("jmpimm_one_uop", n_dut_pops - d0, 1);

        // Fill under backpressure, push+pop while full, JMPIMM first word while full.
        d0 = n_dut_pops;
        cycle(1'b1, 16'h3004, 1'b0);
        cycle(1'b1, 16'h3008, 1'b0);
        cycle(1'b1, 16'h300C, 1'b0);
        check("full_rdy_low", ins_ready, 0);
        cycle(1'b1, 16'h300C, 1'b1);
        cycle(1'b1, 16'h3010, 1'b0);
        check("full_after_pushpop", ins_ready, 0);
        cycle(1'b1, 16'h4000, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0);
        check("ext_waits_full", ins_ready, 0);
        cycle(1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
        end
        check("full_seq_delivered", n_dut_pops - d0, 4);

        // Reset in the middle of a JMPIMM: next word is a fresh instruction.
        cycle(1'b1, 16'h4ABC, 1'b1);
        do_reset();
        cycle(1'b1, 16'h314E, 1'b1);
        @(posedge cpu_clk);
        #1;
        check("post_rst_decode", uop, tbl[0].exp);
        cycle(1'b0, 16'h0000, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] w;
            w = {4'($urandom_range(0, 7)), 12'($urandom)};
            if (n == 300) begin
                do_reset();
            end
            cycle($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6);
        end
        for (int n = 0; n < 8; n++) begin
            cycle(m_wait, 16'($urandom), 1'b1);
        end
        check("drained", uop_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter REG_AW, default 4, register-address width; legal values 3..4; arg_a width is REG_AW+1.
REQ-002 Parameter DEPTH, default 2, micro-op output queue entries; power of two, 2..8.
REQ-003 cpu_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 cpu_rst_n  input  1  asynchronous active-low reset.
REQ-005 ins_valid  input  1  instruction/extension word present on ins.
REQ-006 ins  input  16  instruction word, or extension word while in WAIT_EXT.
REQ-007 ins_ready  output  1  word on ins accepted this cycle when ins_valid & ins_ready.
REQ-008 uop_valid  output  1  queue head holds a micro-op.
REQ-009 uop_ready  input  1  consumer takes queue head when uop_valid & uop_ready.
REQ-010 uop  output  decode_pkg::uop_t  fields read_a, imm_a, arg_a, read_b, src_b, pc_src[1:0], set_pc, add_pc, inc_pc, cmp_b[2:0], out_regs[1:0], imm16[15:0], illegal.
REQ-011 busy  output  1  high in WAIT_EXT or when queue non-empty.

Function
REQ-012 Field extraction: reg A = ins[2 +: REG_AW], reg B = ins[6 +: REG_AW], imm5 = ins[5:1], fn1 = ins[0], fn2 = ins[1:0]; opcode via the shared opcode definitions.
REQ-013 JMP: read_a=1, arg_a={0,regA}, read_b=1, src_b=regB, set_pc=1, pc_src=2'b11, all else 0.
REQ-014 BN: imm_a=1, arg_a=imm5 (zero-extended/truncated to REG_AW+1), read_b=1, src_b=regB, add_pc=1, inc_pc=1, cmp_b={0,fn1,1}, pc_src=2'b01.
REQ-015 B: read_a=1, arg_a={0,regA}, read_b=1, src_b=regB, add_pc=1, inc_pc=1, cmp_b={fn2,1}, pc_src=2'b01.
REQ-016 JMPIMM is two-word: first beat moves FSM IDLE->WAIT_EXT, no micro-op pushed; next accepted beat is the extension word, pushes uop with set_pc=1, pc_src=2'b10, imm16=ext word, others 0; FSM->IDLE.
REQ-017 Any other opcode pushes an all-zero uop (NOP) except illegal per REQ-024.
REQ-018 imm16 is 0 for every micro-op other than JMPIMM.
REQ-019 Latency: accepted single-word instruction (or extension word) visible at uop_valid the following cycle if queue was empty.
REQ-020 ins_ready = (queue not full) | (full & uop_ready this cycle); combinational from uop_ready only, not from ins_valid.
REQ-021 Queue full and simultaneous pop+push: both occur, count unchanged, order preserved; empty and push: no bypass to uop same cycle.
REQ-022 A first-word JMPIMM beat is accepted even when queue full (pushes nothing); the extension beat obeys REQ-020.
REQ-023 Read/write pointers wrap modulo DEPTH; count range 0..DEPTH.

Reset
REQ-024 (moved — see Configuration.)
REQ-025 cpu_rst_n low: FSM=IDLE, queue empty, pointers 0, uop_valid=0, uop fields 0, busy=0, ins_ready=0 while asserted; mid-JMPIMM reset discards the pending first word.
REQ-026 Deassertion takes effect on the first rising edge after release; ins_ready=1 that cycle.

Configuration
REQ-024 Macro DECODE_ILLEGAL_TRAP_EN defined: unknown opcodes push a uop with illegal=1, other fields 0; undefined: illegal port field tied 0, unknown opcodes push NOP.

Structure
REQ-027 decode_pkg holds uop_t, pc_src encodings (SEQ=00, REL=01, IMM=10, REG=11), FSM state enum {IDLE, WAIT_EXT}; opcode values stay in the shared opcode header.
REQ-028 Sub-module decode_queue (DEPTH-entry synchronous FIFO of uop_t, valid/ready both sides); decode logic and FSM stay in decode_pipe.

Verification
REQ-029 Reset mid-JMPIMM (first word accepted, cpu_rst_n low) -> after release, next word decoded as new instruction, no stale imm16.
REQ-030 B with fn2=2'b10, regA=3, regB=5 -> uop arg_a=3, src_b=5, cmp_b=3'b101, pc_src=01, add_pc=inc_pc=1, one cycle later.
REQ-031 JMPIMM then ext 16'hBEEF with one idle cycle between -> exactly one uop, set_pc=1, pc_src=10, imm16=16'hBEEF.
REQ-032 uop_ready=0, stream DEPTH+1 B ops -> ins_ready falls after DEPTH pushes; release uop_ready -> all DEPTH+1 delivered in order, none lost.
REQ-033 Full queue, uop_ready=1, ins_valid=1 same cycle -> push and pop together, count stays DEPTH.
REQ-034 Opcode outside the set, with and without DECODE_ILLEGAL_TRAP_EN -> illegal=1 resp. all-zero NOP uop.
